// File: rtl/ctrl_packer_pkg.sv
// Shared defaults for the control-word packer.
// The state encoding lives inside ctrl_packer; only sizing defaults are shared.
package ctrl_packer_pkg;

  // Default slot count of one output bundle.
  localparam int DEF_NUM_FETCH    = 2;

  // Default width of one decoded control word.
  localparam int DEF_BUFFER_WIDTH = 155;

endpackage

// File: rtl/ctrl_packer_if.sv
// Handshake bundle between the producer, the packer and the bundle consumer.
//
// Handshake rule for both channels: a transfer (fire) happens on a rising clk
// edge where valid and ready are both 1. The producer holds the payload stable
// while valid is high. Ready may depend combinationally on the other channel.
interface ctrl_packer_if
  import ctrl_packer_pkg::*;
#(
  parameter int NUM_FETCH    = DEF_NUM_FETCH,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH
);

  // Input channel: one control word per fire
  logic                              packer_in_control_valid_i;
  logic                              packer_in_control_ready_o;
  logic [BUFFER_WIDTH-1:0]           packer_in_control_signals_i;
  logic                              packer_in_last_i;
  logic                              packer_close_i;

  // Output channel: one closed bundle per fire
  logic                              packer_out_control_valid_o;
  logic                              packer_out_control_ready_i;
  logic [BUFFER_WIDTH*NUM_FETCH-1:0] packer_out_control_signals_o;
  logic [NUM_FETCH-1:0]              packer_out_control_mask_o;

  // Packer side
  modport slave (
    input  packer_in_control_valid_i,
    output packer_in_control_ready_o,
    input  packer_in_control_signals_i,
    input  packer_in_last_i,
    input  packer_close_i,
    output packer_out_control_valid_o,
    input  packer_out_control_ready_i,
    output packer_out_control_signals_o,
    output packer_out_control_mask_o
  );

  // Producer/consumer side
  modport master (
    output packer_in_control_valid_i,
    input  packer_in_control_ready_o,
    output packer_in_control_signals_i,
    output packer_in_last_i,
    output packer_close_i,
    input  packer_out_control_valid_o,
    output packer_out_control_ready_i,
    input  packer_out_control_signals_o,
    input  packer_out_control_mask_o
  );

endinterface

// File: rtl/ctrl_packer_bin2one.sv
// Binary to one-hot decoder: turns the packer write pointer into per-slot
// write enables. Out-of-range codes decode to all zeros.
module bin2one #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [W-1:0] i_bin,
  output logic [N-1:0] o_onehot
);

  // Compare the code against every slot index
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (i_bin == W'(i)) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_packer.sv
// Packs a stream of control words into bundles of NUM_FETCH slots.
// FILL collects words into consecutive slots; HOLD presents the closed bundle
// until the consumer takes it. A new word arriving in the same cycle the held
// bundle leaves starts the next bundle in slot 0 with no bubble.
module ctrl_packer
  import ctrl_packer_pkg::*;
#(
  parameter int NUM_FETCH    = DEF_NUM_FETCH,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  ctrl_packer_if.slave   pk,
  output logic           o_dbg_state
);

  localparam int PTR_W  = $clog2(NUM_FETCH);
  localparam int DATA_W = BUFFER_WIDTH * NUM_FETCH;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     w_wptr_nxt;
  logic [NUM_FETCH-1:0] r_mask;
  logic [NUM_FETCH-1:0] w_mask_nxt;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    w_data_nxt;

  logic [NUM_FETCH-1:0] w_slot_we;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_out_fire;

  // Slot write enables from the write pointer
  bin2one #(
    .N (NUM_FETCH),
    .W (PTR_W)
  ) u_bin2one (
    .i_bin    (r_wptr),
    .o_onehot (w_slot_we)
  );

  // Input is accepted whenever a bundle is open, or when the held bundle leaves
  always_comb begin
    w_in_ready = 1'b1;
    if (r_state == HOLD) begin
      w_in_ready = pk.packer_out_control_ready_i;
    end
  end

  assign w_in_fire  = pk.packer_in_control_valid_i & w_in_ready;
  assign w_out_fire = (r_state == HOLD) & pk.packer_out_control_ready_i;

  assign pk.packer_in_control_ready_o    = w_in_ready;
  assign pk.packer_out_control_valid_o   = (r_state == HOLD);
  assign pk.packer_out_control_signals_o = r_data;
  assign pk.packer_out_control_mask_o    = r_mask;
  assign o_dbg_state                     = r_state;

  // Next-state, pointer, mask and slot data
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_mask_nxt  = r_mask;
    w_data_nxt  = r_data;
    case (r_state)
      FILL: begin
        if (w_in_fire) begin
          // An arriving word wins over a force-close in the same cycle
          for (int i = 0; i < NUM_FETCH; i++) begin
            if (w_slot_we[i]) begin
              w_data_nxt[BUFFER_WIDTH*i +: BUFFER_WIDTH] = pk.packer_in_control_signals_i;
            end
          end
          w_mask_nxt = r_mask | w_slot_we;
          if ((r_wptr == PTR_W'(NUM_FETCH - 1)) || pk.packer_in_last_i) begin
            w_state_nxt = HOLD;
            w_wptr_nxt  = '0;
          end else begin
            w_wptr_nxt  = r_wptr + PTR_W'(1);
          end
        end else if (pk.packer_close_i && (|r_mask)) begin
          // Close an open, non-empty bundle early
          w_state_nxt = HOLD;
          w_wptr_nxt  = '0;
        end
      end
      HOLD: begin
        if (w_out_fire) begin
          w_state_nxt = FILL;
          w_wptr_nxt  = '0;
          w_mask_nxt  = '0;
          w_data_nxt  = '0;
          if (w_in_fire) begin
            // Start the next bundle in slot 0 while the old one leaves
            w_data_nxt[BUFFER_WIDTH-1:0] = pk.packer_in_control_signals_i;
            w_mask_nxt[0]                = 1'b1;
            if (pk.packer_in_last_i) begin
              w_state_nxt = HOLD;
            end else begin
              w_wptr_nxt  = PTR_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // State register; reset beats flush, flush beats every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_wptr  <= '0;
      r_mask  <= '0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_state <= FILL;
      r_wptr  <= '0;
      r_mask  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_mask  <= w_mask_nxt;
      r_data  <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_packer.sv
// Bench for ctrl_packer with NUM_FETCH=2: directed scenarios plus a random
// stream, with closed bundles checked against an expected queue.
module tb_ctrl_packer;

  localparam int NF = 2;
  localparam int BW = 155;
  localparam int DW = NF * BW;

  logic clk;
  logic rst;
  logic flush_i;
  logic dbg_state;

  int errors = 0;
  int checks = 0;

  logic [NF+DW-1:0] exp_q[$];

  ctrl_packer_if #(.NUM_FETCH(NF), .BUFFER_WIDTH(BW)) bus ();

  ctrl_packer #(
    .NUM_FETCH    (NF),
    .BUFFER_WIDTH (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .pk          (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver helpers ----------------
  function automatic logic [BW-1:0] rand_word();
    logic [159:0] t;
    t = '0;
    for (int k = 0; k < 5; k++) t = {t[127:0], 32'($urandom)};
    return t[BW-1:0];
  endfunction

  task automatic drive(input logic v, input logic [BW-1:0] w, input logic last,
                       input logic close, input logic ordy);
    bus.packer_in_control_valid_i   = v;
    bus.packer_in_control_signals_i = w;
    bus.packer_in_last_i            = last;
    bus.packer_close_i              = close;
    bus.packer_out_control_ready_i  = ordy;
  endtask

  // end of a cycle: let the edge happen, then settle
  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && !flush_i && bus.packer_out_control_valid_o && bus.packer_out_control_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bundle %h required none",
                 {bus.packer_out_control_mask_o, bus.packer_out_control_signals_o});
      end else begin
        logic [NF+DW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.packer_out_control_mask_o, bus.packer_out_control_signals_o} !== e) begin
          errors++;
          $display("FAIL sb_bundle: got %h required %h",
                   {bus.packer_out_control_mask_o, bus.packer_out_control_signals_o}, e);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc_end();
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_in_control_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", bus.packer_in_control_ready_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b00) begin errors++; $display("FAIL rst_mask: got %b required 00", bus.packer_out_control_mask_o); end
    checks++; if (bus.packer_out_control_signals_o !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", bus.packer_out_control_signals_o); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b required 0", dbg_state); end
    cyc_end();
    rst = 1'b0;
  endtask

  task automatic test_two_words();
    logic [BW-1:0] a, b;
    a = rand_word(); b = rand_word();
    drive(1'b1, a, 1'b0, 1'b0, 1'b1); cyc_end();
    drive(1'b1, b, 1'b0, 1'b0, 1'b1); exp_q.push_back({2'b11, b, a}); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b1) begin errors++; $display("FAIL two_valid: got %b required 1", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b11) begin errors++; $display("FAIL two_mask: got %b required 11", bus.packer_out_control_mask_o); end
    checks++; if (bus.packer_out_control_signals_o[BW-1:0] !== a) begin errors++; $display("FAIL two_slot0: got %h required %h", bus.packer_out_control_signals_o[BW-1:0], a); end
    checks++; if (bus.packer_out_control_signals_o[2*BW-1:BW] !== b) begin errors++; $display("FAIL two_slot1: got %h required %h", bus.packer_out_control_signals_o[2*BW-1:BW], b); end
    cyc_end();
  endtask

  task automatic test_last();
    logic [BW-1:0] a, x;
    a = rand_word(); x = rand_word();
    drive(1'b1, a, 1'b1, 1'b0, 1'b0); exp_q.push_back({2'b01, {BW{1'b0}}, a}); cyc_end();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, x, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.packer_out_control_valid_o !== 1'b1) begin errors++; $display("FAIL last_valid: got %b required 1", bus.packer_out_control_valid_o); end
      checks++; if (bus.packer_out_control_mask_o !== 2'b01) begin errors++; $display("FAIL last_mask: got %b required 01", bus.packer_out_control_mask_o); end
      checks++; if (bus.packer_out_control_signals_o !== {{BW{1'b0}}, a}) begin errors++; $display("FAIL last_data: got %h required %h", bus.packer_out_control_signals_o, {{BW{1'b0}}, a}); end
      checks++; if (bus.packer_in_control_ready_o !== 1'b0) begin errors++; $display("FAIL last_stall: got %b required 0", bus.packer_in_control_ready_o); end
      cyc_end();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc_end();
  endtask

  task automatic test_hold_release();
    logic [BW-1:0] a, c;
    a = rand_word(); c = rand_word();
    drive(1'b1, a, 1'b1, 1'b0, 1'b0); exp_q.push_back({2'b01, {BW{1'b0}}, a}); cyc_end();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, c, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.packer_in_control_ready_o !== 1'b0) begin errors++; $display("FAIL hr_stall%0d: got %b required 0", k, bus.packer_in_control_ready_o); end
      cyc_end();
    end
    drive(1'b1, c, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.packer_in_control_ready_o !== 1'b1) begin errors++; $display("FAIL hr_release: got %b required 1", bus.packer_in_control_ready_o); end
    cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL hr_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b01) begin errors++; $display("FAIL hr_mask: got %b required 01", bus.packer_out_control_mask_o); end
    checks++; if (bus.packer_out_control_signals_o !== {{BW{1'b0}}, c}) begin errors++; $display("FAIL hr_data: got %h required %h", bus.packer_out_control_signals_o, {{BW{1'b0}}, c}); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL hr_state: got %b required 0", dbg_state); end
    cyc_end();
    // force-close the one-word bundle
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); exp_q.push_back({2'b01, {BW{1'b0}}, c}); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b1) begin errors++; $display("FAIL close_valid: got %b required 1", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b01) begin errors++; $display("FAIL close_mask: got %b required 01", bus.packer_out_control_mask_o); end
    cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc_end();
  endtask

  task automatic test_close();
    logic [BW-1:0] e, f;
    e = rand_word(); f = rand_word();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL empty_close_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b00) begin errors++; $display("FAIL empty_close_mask: got %b required 00", bus.packer_out_control_mask_o); end
    cyc_end();
    // input fire beats close in the same cycle
    drive(1'b1, e, 1'b0, 1'b1, 1'b0); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b01) begin errors++; $display("FAIL prio_mask: got %b required 01", bus.packer_out_control_mask_o); end
    cyc_end();
    drive(1'b1, f, 1'b0, 1'b0, 1'b0); exp_q.push_back({2'b11, f, e}); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.packer_out_control_mask_o !== 2'b11) begin errors++; $display("FAIL prio_full_mask: got %b required 11", bus.packer_out_control_mask_o); end
    cyc_end();
  endtask

  task automatic test_flush();
    drive(1'b1, rand_word(), 1'b1, 1'b0, 1'b0); cyc_end();
    flush_i = 1'b1;
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b0); cyc_end();
    flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b00) begin errors++; $display("FAIL flush_mask: got %b required 00", bus.packer_out_control_mask_o); end
    checks++; if (bus.packer_out_control_signals_o !== '0) begin errors++; $display("FAIL flush_data: got %h required 0", bus.packer_out_control_signals_o); end
    cyc_end();
    // the dropped word must not be there to close
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cyc_end();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b required 0", bus.packer_out_control_valid_o); end
    cyc_end();
  endtask

  task automatic test_reset_hold();
    drive(1'b1, rand_word(), 1'b1, 1'b0, 1'b0); cyc_end();
    rst = 1'b1; flush_i = 1'b1;
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b1); cyc_end();
    rst = 1'b0; flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.packer_out_control_valid_o !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b required 0", bus.packer_out_control_valid_o); end
    checks++; if (bus.packer_in_control_ready_o !== 1'b1) begin errors++; $display("FAIL rh_ready: got %b required 1", bus.packer_in_control_ready_o); end
    checks++; if (bus.packer_out_control_mask_o !== 2'b00) begin errors++; $display("FAIL rh_mask: got %b required 00", bus.packer_out_control_mask_o); end
    checks++; if (bus.packer_out_control_signals_o !== '0) begin errors++; $display("FAIL rh_data: got %h required 0", bus.packer_out_control_signals_o); end
    cyc_end();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] m_data;
    logic [NF-1:0] m_mask;
    int            m_cnt;
    logic          v, l;
    logic [BW-1:0] w;
    m_data = '0; m_mask = '0; m_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      w = rand_word();
      drive(v, w, l, 1'b0, ($urandom_range(0, 3) != 0));
      @(negedge clk);
      if (v && bus.packer_in_control_ready_o) begin
        m_data[BW*m_cnt +: BW] = w;
        m_mask[m_cnt] = 1'b1;
        m_cnt++;
        if (m_cnt == NF || l) begin
          exp_q.push_back({m_mask, m_data});
          m_data = '0; m_mask = '0; m_cnt = 0;
        end
      end
      cyc_end();
    end
    if (m_cnt > 0) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      exp_q.push_back({m_mask, m_data});
      cyc_end();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc_end();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_two_words();
    test_last();
    test_hold_release();
    test_close();
    test_flush();
    test_reset_hold();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
